mem_arbiter: RTL and testbench

//  Shares the single data port of the unified RAM/GPIO memory between two requesters:
//  m0 = CPU load/store unit, m1 = debug/program loader. Registers the winning command

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_rr_pick.sv | 35 +++
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory port arbiter.
// Holds the FSM state encoding, default bus widths and a small helper that
// turns a master index into a one-hot grant vector.
package mem_arbiter_pkg;

  localparam int AW_DEFAULT = 32;
  localparam int DW_DEFAULT = 32;
  localparam int MW_DEFAULT = DW_DEFAULT / 8;

  // IDLE picks a winner, ISSUE drives the memory port, RESP returns the ack.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arbState_e;

  function automatic logic [1:0] toOneHot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way request picker for mem_arbiter.
// Ports:
//   req_i      requests, bit N = master N
//   last_i     master granted most recently (0 = m0, 1 = m1)
//   rr_i       1 = round-robin on a tie, 0 = m0 always wins a tie
//   lockEn_i   1 = only lockOwn_i may be granted
//   lockOwn_i  master holding the lock
//   gnt_o      one-hot winner, 0 when nobody is eligible
module mem_arb_rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       rr_i,
  input  logic       lockEn_i,
  input  logic       lockOwn_i,
  output logic [1:0] gnt_o
);

  logic [1:0] eligible;

  // A held lock masks the other master out before tie-breaking, so a lone
  // request from the non-owner is simply left waiting.
  always_comb begin
    eligible = req_i;
    if (lockEn_i) begin
      eligible = req_i & toOneHot(lockOwn_i);
    end
    gnt_o = eligible;
    if (eligible == 2'b11) begin
      gnt_o = (rr_i && !last_i) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM/GPIO data port between m0 (CPU load/store unit)
// and m1 (debug/program loader). The winning command is registered onto the
// memory port, held through memory stalls, and completed with a one-cycle ack
// that carries the read data (zero for writes).
// Ports:
//   I_clk, I_rst                  clock, synchronous active-high reset
//   I_mN_req/addr/wdata/mask/we   master N command, held until O_mN_ack
//   I_mN_lock                     keep ownership after this access
//   O_mN_ack, O_mN_rdata          completion pulse and read data
//   O_s_addr/data/mask/we         registered memory command
//   I_s_rdata, I_s_stall          memory read data and not-ready
//   O_gnt                         one-hot owner during ISSUE/RESP
// Build option: define MEM_ARB_LOCK_EN to enable bus locking; without it the
// lock inputs are ignored and no lock state exists.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT,
  parameter int MW = MW_DEFAULT,
  parameter int RR = 1
) (
  input  logic          I_clk,
  input  logic          I_rst,
  input  logic          I_m0_req,
  input  logic [AW-1:0] I_m0_addr,
  input  logic [DW-1:0] I_m0_wdata,
  input  logic [MW-1:0] I_m0_mask,
  input  logic          I_m0_we,
  input  logic          I_m0_lock,
  output logic          O_m0_ack,
  output logic [DW-1:0] O_m0_rdata,
  input  logic          I_m1_req,
  input  logic [AW-1:0] I_m1_addr,
  input  logic [DW-1:0] I_m1_wdata,
  input  logic [MW-1:0] I_m1_mask,
  input  logic          I_m1_we,
  input  logic          I_m1_lock,
  output logic          O_m1_ack,
  output logic [DW-1:0] O_m1_rdata,
  output logic [AW-1:0] O_s_addr,
  output logic [DW-1:0] O_s_data,
  output logic [MW-1:0] O_s_mask,
  output logic          O_s_we,
  input  logic [DW-1:0] I_s_rdata,
  input  logic          I_s_stall,
  output logic [1:0]    O_gnt
);

  arbState_e     state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          last_q, last_d;
  logic [AW-1:0] sAddr_q, sAddr_d;
  logic [DW-1:0] sData_q, sData_d;
  logic [MW-1:0] sMask_q, sMask_d;
  logic [1:0]    pickGnt;
  logic          lockActive;
  logic          lockOwner;

`ifdef MEM_ARB_LOCK_EN
  logic locked_q, locked_d;
  logic lockOwn_q, lockOwn_d;
  assign lockActive = locked_q;
  assign lockOwner  = lockOwn_q;
`else
  logic unusedLock;
  assign unusedLock = I_m0_lock ^ I_m1_lock;
  assign lockActive = 1'b0;
  assign lockOwner  = 1'b0;
`endif

  mem_arb_rr_pick uPick (
    .req_i     ({I_m1_req, I_m0_req}),
    .last_i    (last_q),
    .rr_i      (RR != 0),
    .lockEn_i  (lockActive),
    .lockOwn_i (lockOwner),
    .gnt_o     (pickGnt)
  );

  // Next-state logic: the winner's command is captured on leaving IDLE and
  // held unchanged on the memory port until the access completes.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    last_d  = last_q;
    sAddr_d = sAddr_q;
    sData_d = sData_q;
    sMask_d = sMask_q;
`ifdef MEM_ARB_LOCK_EN
    locked_d  = locked_q;
    lockOwn_d = lockOwn_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pickGnt != 2'b00) begin
          state_d = ST_ISSUE;
          owner_d = pickGnt[1];
          sAddr_d = pickGnt[1] ? I_m1_addr  : I_m0_addr;
          sData_d = pickGnt[1] ? I_m1_wdata : I_m0_wdata;
          sMask_d = pickGnt[1] ? I_m1_mask  : I_m0_mask;
          we_d    = pickGnt[1] ? I_m1_we    : I_m0_we;
        end
      end
      ST_ISSUE: begin
        if (!I_s_stall) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        last_d  = owner_q;
`ifdef MEM_ARB_LOCK_EN
        // The owner's lock bit at completion decides whether it keeps the bus.
        locked_d  = owner_q ? I_m1_lock : I_m0_lock;
        lockOwn_d = owner_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: ack and read data exist only in RESP, write enable only in
  // ISSUE, so a stalled write is simply re-presented to the memory.
  always_comb begin
    O_m0_ack   = 1'b0;
    O_m1_ack   = 1'b0;
    O_m0_rdata = '0;
    O_m1_rdata = '0;
    O_gnt      = 2'b00;
    O_s_we     = 1'b0;
    if (state_q == ST_ISSUE) begin
      O_s_we = we_q;
    end
    if (state_q != ST_IDLE) begin
      O_gnt = toOneHot(owner_q);
    end
    if (state_q == ST_RESP) begin
      if (owner_q) begin
        O_m1_ack   = 1'b1;
        O_m1_rdata = we_q ? '0 : I_s_rdata;
      end else begin
        O_m0_ack   = 1'b1;
        O_m0_rdata = we_q ? '0 : I_s_rdata;
      end
    end
  end

  assign O_s_addr = sAddr_q;
  assign O_s_data = sData_q;
  assign O_s_mask = sMask_q;

  // State register. The last-grant pointer resets to m1 so m0 wins the
  // first tie; an access in flight at reset is dropped without an ack.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      last_q  <= 1'b1;
      sAddr_q <= '0;
      sData_q <= '0;
      sMask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      last_q  <= last_d;
      sAddr_q <= sAddr_d;
      sData_q <= sData_d;
      sMask_q <= sMask_d;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  // Lock state, cleared by reset or by an owner access completing unlocked.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      locked_q  <= 1'b0;
      lockOwn_q <= 1'b0;
    end else begin
      locked_q  <= locked_d;
      lockOwn_q <= lockOwn_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. Main instance runs round-robin; a second instance
// with fixed priority shows m1 starvation. The bench acts as the memory and
// keeps its own shadow copy of memory contents plus an access-level model of
// who should win each arbitration. Lock scenarios are built when
// MEM_ARB_LOCK_EN is defined.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        memInit;
  logic        mReq[2];
  logic [31:0] mAddr[2];
  logic [31:0] mWdata[2];
  logic [3:0]  mMask[2];
  logic        mWe[2];
  logic        mLock[2];
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] sAddr, sData, sRdata;
  logic [3:0]  sMask;
  logic        sWe, sStall;
  logic [1:0]  gnt;

  // Fixed-priority instance signals
  logic        fpReq0, fpReq1;
  logic        fpAck0, fpAck1;
  logic [1:0]  fpGnt;
  logic [31:0] fpSAddr;
  logic [31:0] unusedFpRdata0, unusedFpRdata1, unusedFpSData;
  logic [3:0]  unusedFpSMask;
  logic        unusedFpSWe;

  int checkCount = 0;
  int failCount  = 0;

  // Model and command state
  bit          pend[2];
  logic [31:0] cAddr[2];
  logic [31:0] cData[2];
  logic [3:0]  cMask[2];
  logic        cWe[2];
  logic        cLock[2];
  logic [31:0] shadow[256];
  logic [31:0] envMem[256];
  logic [31:0] lastRdata;
  int          lastM;
`ifdef MEM_ARB_LOCK_EN
  bit          lockedM;
  int          lockOwnM;
`endif

  mem_arbiter #(.RR(1)) dut (
    .I_clk(clk), .I_rst(rst),
    .I_m0_req(mReq[0]), .I_m0_addr(mAddr[0]), .I_m0_wdata(mWdata[0]),
    .I_m0_mask(mMask[0]), .I_m0_we(mWe[0]), .I_m0_lock(mLock[0]),
    .O_m0_ack(ack0), .O_m0_rdata(rdata0),
    .I_m1_req(mReq[1]), .I_m1_addr(mAddr[1]), .I_m1_wdata(mWdata[1]),
    .I_m1_mask(mMask[1]), .I_m1_we(mWe[1]), .I_m1_lock(mLock[1]),
    .O_m1_ack(ack1), .O_m1_rdata(rdata1),
    .O_s_addr(sAddr), .O_s_data(sData), .O_s_mask(sMask), .O_s_we(sWe),
    .I_s_rdata(sRdata), .I_s_stall(sStall), .O_gnt(gnt)
  );

  mem_arbiter #(.RR(0)) dutFp (
    .I_clk(clk), .I_rst(rst),
    .I_m0_req(fpReq0), .I_m0_addr(32'h0000_0040), .I_m0_wdata(32'h0),
    .I_m0_mask(4'hF), .I_m0_we(1'b0), .I_m0_lock(1'b0),
    .O_m0_ack(fpAck0), .O_m0_rdata(unusedFpRdata0),
    .I_m1_req(fpReq1), .I_m1_addr(32'h0000_0080), .I_m1_wdata(32'h0),
    .I_m1_mask(4'hF), .I_m1_we(1'b0), .I_m1_lock(1'b0),
    .O_m1_ack(fpAck1), .O_m1_rdata(unusedFpRdata1),
    .O_s_addr(fpSAddr), .O_s_data(unusedFpSData), .O_s_mask(unusedFpSMask),
    .O_s_we(unusedFpSWe), .I_s_rdata(32'h0), .I_s_stall(1'b0), .O_gnt(fpGnt)
  );

  function automatic logic [31:0] memInitWord(input int i);
    if (i == 64) return 32'hDEADBEEF;
    if (i >= 128) return 32'h0;
    return 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
  endfunction

  // Behaves like the RAM: byte-masked write when the write is accepted,
  // read data registered one cycle after the address.
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 256; i++) envMem[i] <= memInitWord(i);
    end else if (sWe && !sStall) begin
      for (int b = 0; b < 4; b++)
        if (sMask[b]) envMem[sAddr[9:2]][8*b +: 8] <= sData[8*b +: 8];
    end
    sRdata <= envMem[sAddr[9:2]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 2; i++) begin
      mReq[i]   = pend[i];
      mAddr[i]  = cAddr[i];
      mWdata[i] = cData[i];
      mMask[i]  = cMask[i];
      mWe[i]    = cWe[i];
      mLock[i]  = cLock[i];
    end
  endtask

  task automatic setCommand(input int i, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m, input logic we, input logic lk);
    pend[i] = 1'b1; cAddr[i] = a; cData[i] = d; cMask[i] = m; cWe[i] = we; cLock[i] = lk;
  endtask

  task automatic newCommand(input int i);
    int idx;
    idx = $urandom_range(60, 70);
    setCommand(i, 32'(idx) << 2, $urandom, 4'($urandom_range(1, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
  endtask

  // Winner by the arbitration rules: lock owner only, else a lone requester,
  // else the master that did not win last time.
  function automatic int modelPick();
    bit e0, e1;
    e0 = pend[0];
    e1 = pend[1];
`ifdef MEM_ARB_LOCK_EN
    if (lockedM) begin
      if (lockOwnM == 0) e1 = 1'b0; else e0 = 1'b0;
    end
`endif
    if (e0 && e1) return (lastM == 0) ? 1 : 0;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  // One arbitration slot starting in an IDLE cycle with inputs already driven.
  task automatic runAccess(input int stalls, output int w);
    int lastK;
    int idx;
    w = modelPick();
    if (w < 0) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        checkOutput("waitAck0", 32'(ack0), 32'd0);
        checkOutput("waitAck1", 32'(ack1), 32'd0);
        checkOutput("waitGnt", 32'(gnt), 32'd0);
        @(posedge clk); #1;
      end
      return;
    end
    lastK = 2 + stalls;
    for (int k = 0; k <= lastK; k++) begin
      sStall = (k >= 1 && k <= stalls);
      @(negedge clk);
      checkOutput("ack0", 32'(ack0), 32'(w == 0 && k == lastK));
      checkOutput("ack1", 32'(ack1), 32'(w == 1 && k == lastK));
      checkOutput("gnt", 32'(gnt), (k == 0) ? 32'd0 : ((w == 1) ? 32'd2 : 32'd1));
      checkOutput("sWe", 32'(sWe), (k >= 1 && k < lastK) ? 32'(cWe[w]) : 32'd0);
      if (k >= 1 && k < lastK) checkOutput("sAddr", sAddr, cAddr[w]);
      if (k == 1) begin
        checkOutput("sMask", 32'(sMask), 32'(cMask[w]));
        if (cWe[w]) checkOutput("sData", sData, cData[w]);
      end
      if (k == lastK) begin
        idx = int'(cAddr[w][9:2]);
        lastRdata = (w == 1) ? rdata1 : rdata0;
        checkOutput("rdata", lastRdata, cWe[w] ? 32'd0 : shadow[idx]);
        if (cWe[w])
          for (int b = 0; b < 4; b++)
            if (cMask[w][b]) shadow[idx][8*b +: 8] = cData[w][8*b +: 8];
        lastM = w;
`ifdef MEM_ARB_LOCK_EN
        lockedM  = cLock[w];
        lockOwnM = w;
`endif
        pend[w] = 1'b0;
      end
      @(posedge clk); #1;
    end
    sStall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w, prevW, fpAckCount, stalls;
    rst = 1'b1; memInit = 1'b1; sStall = 1'b0;
    fpReq0 = 1'b0; fpReq1 = 1'b0;
    for (int i = 0; i < 2; i++) setCommand(i, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    pend[0] = 1'b0; pend[1] = 1'b0;
    applyStimulus();
    for (int i = 0; i < 256; i++) shadow[i] = memInitWord(i);
    lastM = 1;
`ifdef MEM_ARB_LOCK_EN
    lockedM = 1'b0; lockOwnM = 0;
`endif
    repeat (2) @(posedge clk);
    #1 memInit = 1'b0;
    @(negedge clk);
    checkOutput("rstAck0", 32'(ack0), 32'd0);
    checkOutput("rstAck1", 32'(ack1), 32'd0);
    checkOutput("rstGnt", 32'(gnt), 32'd0);
    checkOutput("rstSAddr", sAddr, 32'd0);
    checkOutput("rstSWe", 32'(sWe), 32'd0);
    checkOutput("rstRdata0", rdata0, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Fixed priority: both request constantly, only m0 is ever served.
    fpReq0 = 1'b1; fpReq1 = 1'b1; fpAckCount = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checkOutput("fpAck1", 32'(fpAck1), 32'd0);
      checkOutput("fpGnt", 32'(fpGnt), (k % 3 == 0) ? 32'd0 : 32'd1);
      if (k % 3 == 1) checkOutput("fpSAddr", fpSAddr, 32'h40);
      fpAckCount += int'(fpAck0);
      @(posedge clk); #1;
    end
    fpReq0 = 1'b0; fpReq1 = 1'b0;
    checkOutput("fpAck0Count", 32'(fpAckCount), 32'd3);

    // Read of a preloaded word.
    setCommand(0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0);
    applyStimulus(); runAccess(0, w);
    checkOutput("t1Winner", 32'(w), 32'd0);
    checkOutput("t1Data", lastRdata, 32'hDEADBEEF);

    // Masked write from m1 then read-back from m0.
    setCommand(1, 32'h200, 32'h12345678, 4'b0011, 1'b1, 1'b0);
    applyStimulus(); runAccess(0, w);
    checkOutput("t2WrWinner", 32'(w), 32'd1);
    setCommand(0, 32'h200, 32'h0, 4'hF, 1'b0, 1'b0);
    applyStimulus(); runAccess(0, w);
    checkOutput("t2Low", lastRdata, 32'h00005678);

    // Both request continuously: grants must alternate.
    prevW = 0;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 2; i++) if (!pend[i]) newCommand(i);
      applyStimulus(); runAccess(0, w);
      checkOutput("t3Alternate", 32'(w != prevW), 32'd1);
      prevW = w;
    end
    pend[0] = 1'b0; pend[1] = 1'b0;

    // Three stall cycles push the ack out to cycle 5.
    setCommand(0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0);
    applyStimulus(); runAccess(3, w);
    checkOutput("t4Data", lastRdata, 32'hDEADBEEF);

    // Reset during ISSUE abandons the access.
    setCommand(0, 32'h104, 32'h0, 4'hF, 1'b0, 1'b0);
    applyStimulus();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("t6IssueGnt", 32'(gnt), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    pend[0] = 1'b0; applyStimulus();
    lastM = 1;
`ifdef MEM_ARB_LOCK_EN
    lockedM = 1'b0;
`endif
    @(negedge clk);
    checkOutput("t6Ack0", 32'(ack0), 32'd0);
    checkOutput("t6Ack1", 32'(ack1), 32'd0);
    checkOutput("t6Gnt", 32'(gnt), 32'd0);
    checkOutput("t6SAddr", sAddr, 32'd0);
    checkOutput("t6SData", sData, 32'd0);
    checkOutput("t6SMask", 32'(sMask), 32'd0);
    checkOutput("t6SWe", 32'(sWe), 32'd0);
    @(posedge clk); #1;
    newCommand(0); newCommand(1);
    applyStimulus(); runAccess(0, w);
    checkOutput("t6TieAfterReset", 32'(w), 32'd0);
    applyStimulus(); runAccess(0, w);
    checkOutput("t6Drain", 32'(w), 32'd1);

`ifdef MEM_ARB_LOCK_EN
    // m1 locks the bus; m0 waits until m1 completes an unlocked access.
    setCommand(1, 32'h100, 32'h0, 4'hF, 1'b0, 1'b1);
    applyStimulus(); runAccess(0, w);
    checkOutput("t5First", 32'(w), 32'd1);
    setCommand(0, 32'h104, 32'h0, 4'hF, 1'b0, 1'b0);
    applyStimulus(); runAccess(0, w);
    checkOutput("t5Blocked", 32'(w), 32'hFFFF_FFFF);
    setCommand(1, 32'h108, 32'h0, 4'hF, 1'b0, 1'b0);
    applyStimulus(); runAccess(0, w);
    checkOutput("t5Second", 32'(w), 32'd1);
    applyStimulus(); runAccess(0, w);
    checkOutput("t5Third", 32'(w), 32'd0);
`endif

    // Randomized traffic against the model.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 2; i++) if (!pend[i] && $urandom_range(0, 1) == 1) newCommand(i);
      if (!pend[0] && !pend[1]) newCommand(int'($urandom_range(0, 1)));
`ifdef MEM_ARB_LOCK_EN
      if (lockedM && !pend[lockOwnM]) newCommand(lockOwnM);
`endif
      applyStimulus();
      stalls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      runAccess(stalls, w);
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    applyStimulus();

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
